m_cache_refill_ctrl: RTL and testbench

- Read-only controller sequencing the 2-way set-associative instruction/data cache, i.e. the 32-set, 58-bit-line cache.
- Accepts one CPU read at a time and performs the cache lookup.
- On a hit, returns the cached word.
- On a miss, fetches the word from backing memory over a req/ack handshake, writes the line into the cache fill port, then returns the word.
- Keeps saturating hit/miss counters for performance monitoring.

---
 rtl/m_cache_refill_ctrl_if.sv | 37 +++
 rtl/m_cache_refill_ctrl.sv | 114 +++++++++++
 tb/tb_m_cache_refill_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_cache_refill_ctrl_if.sv
// rtl/m_cache_refill_ctrl_if.sv - CPU, cache lookup/fill, memory and counter signals of the refill controller
interface m_cache_refill_ctrl_if #(
    parameter int TAG_W   = 25,
    parameter int INDEX_W = 5
);
    logic                 w_req;
    logic [31:0]          w_addr;
    logic                 w_ready;
    logic                 w_rvalid;
    logic [31:0]          w_rdata;
    logic [31:0]          w_c_addr;
    logic                 w_c_hit;
    logic [31:0]          w_c_dout;
    logic [INDEX_W-1:0]   w_c_wa;
    logic                 w_c_we;
    logic [TAG_W+32:0]    w_c_wd;
    logic                 w_mem_req;
    logic [31:0]          w_mem_addr;
    logic                 w_mem_ack;
    logic [31:0]          w_mem_data;
    logic [31:0]          w_hit_cnt;
    logic [31:0]          w_miss_cnt;

    // Controller side
    modport slave (
        input  w_req, w_addr, w_c_hit, w_c_dout, w_mem_ack, w_mem_data,
        output w_ready, w_rvalid, w_rdata, w_c_addr, w_c_wa, w_c_we, w_c_wd,
               w_mem_req, w_mem_addr, w_hit_cnt, w_miss_cnt
    );

    // CPU / cache / memory side
    modport master (
        output w_req, w_addr, w_c_hit, w_c_dout, w_mem_ack, w_mem_data,
        input  w_ready, w_rvalid, w_rdata, w_c_addr, w_c_wa, w_c_we, w_c_wd,
               w_mem_req, w_mem_addr, w_hit_cnt, w_miss_cnt
    );
endinterface

// File: rtl/m_cache_refill_ctrl.sv
// rtl/m_cache_refill_ctrl.sv - read-only lookup/refill sequencer for a 2-way set-associative cache
module m_cache_refill_ctrl #(
    parameter int TAG_W   = 25,
    parameter int INDEX_W = 5
) (
    input  logic                  w_clock,
    input  logic                  w_reset_n,
    m_cache_refill_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_REQ,
        S_FILL,
        S_RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] rdata_q;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    logic        ready;
    logic        rvalid;
    logic        c_we;
    logic        mem_req;

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Strobes are decoded from state alone so reset removes them asynchronously
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        rvalid     = 1'b0;
        c_we       = 1'b0;
        mem_req    = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.w_req) next_state = S_LOOKUP;
            end
            S_LOOKUP: begin
                next_state = bus.w_c_hit ? S_RESP : S_MEM_REQ;
            end
            S_MEM_REQ: begin
                mem_req = 1'b1;
                if (bus.w_mem_ack) next_state = S_FILL;
            end
            S_FILL: begin
                c_we       = 1'b1;
                next_state = S_RESP;
            end
            S_RESP: begin
                rvalid     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // rdata_q is loaded on entry to RESP so the output only changes with a new response
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_addr   <= 32'd0;
            r_data   <= 32'd0;
            rdata_q  <= 32'd0;
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.w_req) r_addr <= bus.w_addr & 32'hFFFF_FFFC;
                end
                S_LOOKUP: begin
                    if (bus.w_c_hit) begin
                        r_data  <= bus.w_c_dout;
                        rdata_q <= bus.w_c_dout;
                        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
                    end else begin
                        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
                    end
                end
                S_MEM_REQ: begin
                    if (bus.w_mem_ack) r_data <= bus.w_mem_data;
                end
                S_FILL: begin
                    rdata_q <= r_data;
                end
                default: ;
            endcase
        end
    end

    assign bus.w_ready    = ready;
    assign bus.w_rvalid   = rvalid;
    assign bus.w_rdata    = rdata_q;
    assign bus.w_c_addr   = r_addr;
    assign bus.w_c_we     = c_we;
    assign bus.w_c_wa     = r_addr[INDEX_W+1:2];
    assign bus.w_c_wd     = {1'b1, r_addr[31:INDEX_W+2], r_data};
    assign bus.w_mem_req  = mem_req;
    assign bus.w_mem_addr = r_addr;
    assign bus.w_hit_cnt  = hit_cnt;
    assign bus.w_miss_cnt = miss_cnt;
endmodule

// File: tb/tb_m_cache_refill_ctrl.sv
// tb/tb_m_cache_refill_ctrl.sv - scoreboard bench for m_cache_refill_ctrl with cache and memory models
module tb_m_cache_refill_ctrl;
    localparam int TAG_W   = 25;
    localparam int INDEX_W = 5;
    localparam int NSETS   = 1 << INDEX_W;

    localparam int MEM_NORMAL = 0;
    localparam int MEM_TIE    = 1;
    localparam int MEM_MANUAL = 2;

    logic w_clock;
    logic w_reset_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    m_cache_refill_ctrl_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) bus ();

    m_cache_refill_ctrl #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) dut (
        .w_clock   (w_clock),
        .w_reset_n (w_reset_n),
        .bus       (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [INDEX_W-1:0] wa;
        logic [TAG_W+32:0]  wd;
    } fill_t;

    rsp_t        rq[$];
    fill_t       fq[$];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
    int          mem_req_starts;

    int          mem_mode;
    int          mem_wait;
    int          mw_cnt;
    logic [31:0] cur_addr;
    logic        manual_ack;

    logic               m_valid [2][NSETS] = '{default: 1'b0};
    logic [TAG_W-1:0]   m_tag   [2][NSETS] = '{default: '0};
    logic [31:0]        m_data  [2][NSETS] = '{default: '0};
    logic               m_lru   [NSETS]    = '{default: 1'b0};

    initial begin
        w_clock = 1'b0;
        forever #5 w_clock = ~w_clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge w_clock);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
    endfunction

    function automatic logic predict_hit(input logic [31:0] a);
        logic [INDEX_W-1:0] idx;
        idx = a[INDEX_W+1:2];
        for (int w = 0; w < 2; w++)
            if (m_valid[w][idx] && m_tag[w][idx] == a[31:INDEX_W+2]) return 1'b1;
        return 1'b0;
    endfunction

    // Two-way cache model: combinational lookup, fill into an empty way else the older way
    always_comb begin
        bus.w_c_hit  = 1'b0;
        bus.w_c_dout = 32'd0;
        for (int w = 0; w < 2; w++) begin
            if (m_valid[w][bus.w_c_addr[INDEX_W+1:2]] &&
                m_tag[w][bus.w_c_addr[INDEX_W+1:2]] == bus.w_c_addr[31:INDEX_W+2]) begin
                bus.w_c_hit  = 1'b1;
                bus.w_c_dout = m_data[w][bus.w_c_addr[INDEX_W+1:2]];
            end
        end
    end

    always @(posedge w_clock) begin
        logic way;
        if (bus.w_c_we) begin
            if (!m_valid[0][bus.w_c_wa])      way = 1'b0;
            else if (!m_valid[1][bus.w_c_wa]) way = 1'b1;
            else                              way = m_lru[bus.w_c_wa];
            m_valid[way][bus.w_c_wa] <= bus.w_c_wd[TAG_W+32];
            m_tag[way][bus.w_c_wa]   <= bus.w_c_wd[TAG_W+31:32];
            m_data[way][bus.w_c_wa]  <= bus.w_c_wd[31:0];
            m_lru[bus.w_c_wa]        <= ~way;
        end
    end

    // Memory model: acks after mem_wait idle cycles of w_mem_req, or tied high, or manual
    always @(negedge w_clock) begin
        if (mem_mode == MEM_TIE) begin
            bus.w_mem_ack  = 1'b1;
            bus.w_mem_data = mem_val(bus.w_mem_addr);
            mw_cnt         = 0;
        end else if (mem_mode == MEM_MANUAL) begin
            bus.w_mem_ack  = manual_ack;
            bus.w_mem_data = 32'h5A5A_5A5A;
            mw_cnt         = 0;
        end else if (bus.w_mem_req && !bus.w_mem_ack) begin
            if (mw_cnt >= mem_wait) begin
                bus.w_mem_ack  = 1'b1;
                bus.w_mem_data = mem_val(bus.w_mem_addr);
                mw_cnt         = 0;
                check("mem_addr", bus.w_mem_addr, cur_addr);
            end else begin
                mw_cnt = mw_cnt + 1;
            end
        end else begin
            bus.w_mem_ack = 1'b0;
            if (!bus.w_mem_req) mw_cnt = 0;
        end
    end

    initial begin
        rsp_t  r;
        fill_t f;
        logic  prev_req;
        prev_req = 1'b0;
        mem_req_starts = 0;
        forever begin
            @(negedge w_clock);
            if (w_reset_n) begin
                if (bus.w_mem_req && !prev_req) mem_req_starts = mem_req_starts + 1;
                if (bus.w_rvalid) begin
                    if (rq.size() == 0) begin
                        check("rvalid_unexpected", 1, 0);
                    end else begin
                        r = rq.pop_front();
                        check("rdata", bus.w_rdata, r.data);
                        check("latency", cyc - r.acc, r.lat);
                    end
                end
                if (bus.w_c_we) begin
                    if (fq.size() == 0) begin
                        check("fill_unexpected", 1, 0);
                    end else begin
                        f = fq.pop_front();
                        check("fill_wa", bus.w_c_wa, f.wa);
                        check("fill_wd", bus.w_c_wd, f.wd);
                    end
                end
            end
            prev_req = bus.w_mem_req;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge w_clock);
        while (!bus.w_ready && n < 60) begin
            @(negedge w_clock);
            n++;
        end
        if (!bus.w_ready) check("ready_timeout", 0, 1);
    endtask

    // Accept one request and queue its expected response (and fill on a miss)
    task automatic accept(input logic [31:0] a, input int wait_cycles, input logic keep_req);
        logic  hit;
        rsp_t  r;
        fill_t f;
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        hit = predict_hit(wa);
        cur_addr = wa;
        mem_wait = wait_cycles;
        bus.w_addr = a;
        bus.w_req  = 1'b1;
        @(posedge w_clock);
        #1;
        if (!keep_req) bus.w_req = 1'b0;
        r.data = mem_val(wa);
        r.acc  = cyc;
        r.lat  = hit ? 1 : 3 + wait_cycles;
        rq.push_back(r);
        if (hit) begin
            if (exp_hits != 32'hFFFF_FFFF) exp_hits = exp_hits + 1;
        end else begin
            if (exp_misses != 32'hFFFF_FFFF) exp_misses = exp_misses + 1;
            f.wa = wa[INDEX_W+1:2];
            f.wd = {1'b1, wa[31:INDEX_W+2], mem_val(wa)};
            fq.push_back(f);
        end
    endtask

    task automatic read(input logic [31:0] a, input int wait_cycles);
        wait_ready();
        accept(a, wait_cycles, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || fq.size() != 0 || !bus.w_ready) && n < 200) begin
            @(negedge w_clock);
            n++;
        end
        check("drain_timeout", (rq.size() != 0 || fq.size() != 0) ? 1 : 0, 0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit_cnt"}, bus.w_hit_cnt, exp_hits);
        check({tag, "_miss_cnt"}, bus.w_miss_cnt, exp_misses);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   starts;
        int   prev_acc;
        n_checks   = 0;
        n_fail     = 0;
        exp_hits   = 0;
        exp_misses = 0;
        mem_mode   = MEM_NORMAL;
        mem_wait   = 0;
        mw_cnt     = 0;
        manual_ack = 1'b0;
        cur_addr   = 0;
        bus.w_req      = 1'b0;
        bus.w_addr     = 32'd0;
        bus.w_mem_ack  = 1'b0;
        bus.w_mem_data = 32'd0;
        w_reset_n = 1'b0;
        repeat (3) @(negedge w_clock);
        check("rst_ready", bus.w_ready, 1);
        check("rst_rvalid", bus.w_rvalid, 0);
        check("rst_c_we", bus.w_c_we, 0);
        check("rst_mem_req", bus.w_mem_req, 0);
        check("rst_rdata", bus.w_rdata, 0);
        check_counters("rst");
        w_reset_n = 1'b1;

        // Cold miss with three wait cycles, then the same address hits without memory traffic
        read(32'h0000_0040, 3);
        drain();
        check_counters("miss40");
        starts = mem_req_starts;
        read(32'h0000_0042, 0);
        drain();
        check("hit40_no_mem_req", mem_req_starts - starts, 0);
        check_counters("hit40");

        // Two tags sharing set 3 both stay resident
        read(32'h0000_000C, 1);
        read(32'h0000_008C, 2);
        read(32'h0000_000C, 0);
        read(32'h0000_008C, 0);
        drain();
        check_counters("conflict");

        // w_req held high with w_mem_ack tied high: one accept every 5 cycles
        mem_mode = MEM_TIE;
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ready();
            accept(32'h0000_2000 + 32'(i * 4), 0, 1'b1);
            if (i > 0) check("issue_interval", rq[rq.size()-1].acc - prev_acc, 5);
            prev_acc = rq[rq.size()-1].acc;
        end
        bus.w_req = 1'b0;
        drain();
        mem_mode = MEM_NORMAL;
        @(negedge w_clock);
        check_counters("tied");

        // Reset while waiting on memory, followed by a stray ack
        read(32'h0000_3000, 40);
        repeat (4) @(negedge w_clock);
        check("pre_rst_mem_req", bus.w_mem_req, 1);
        #2;
        w_reset_n = 1'b0;
        #1;
        check("arst_mem_req", bus.w_mem_req, 0);
        check("arst_c_we", bus.w_c_we, 0);
        check("arst_ready", bus.w_ready, 1);
        rq.delete();
        fq.delete();
        exp_hits   = 0;
        exp_misses = 0;
        check_counters("arst");
        mem_mode   = MEM_MANUAL;
        manual_ack = 1'b1;
        @(negedge w_clock);
        w_reset_n = 1'b1;
        repeat (5) @(negedge w_clock);
        check("late_ack_ready", bus.w_ready, 1);
        check("late_ack_rvalid", bus.w_rvalid, 0);
        manual_ack = 1'b0;
        mem_mode   = MEM_NORMAL;
        repeat (2) @(negedge w_clock);
        check_counters("late_ack");

        // Counter saturation
        @(negedge w_clock);
        force dut.hit_cnt  = 32'hFFFF_FFFE;
        force dut.miss_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt;
        release dut.miss_cnt;
        exp_hits   = 32'hFFFF_FFFE;
        exp_misses = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) read(32'h0000_0040, 0);
        for (int i = 0; i < 3; i++) read(32'h0000_4000 + 32'(i * 32'h100), i);
        drain();
        check_counters("sat");
        check("sat_hit_value", bus.w_hit_cnt, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
